// File: rtl/silife_vga_pkg.sv
// Shared 640x480@60 VGA timing constants for the SiLife display path (generator and capture),
// plus the capture FSM state type.
package silife_vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Wide enough to hold H_TOTAL itself, so a full line length can be compared exactly.
    localparam int H_CNT_W = $clog2(H_TOTAL) + 1;

    typedef enum logic [1:0] {
        IDLE,
        VBLANK,
        ACTIVE
    } capture_state_t;

endpackage

// File: rtl/silife_vga_sync_edge.sv
// Registers the active-low VGA sync inputs and produces single-cycle edge strobes
// in the same cycle the new level is first seen.
module silife_vga_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_hsync,
    input  logic i_vsync,
    output logic hsync_rise,
    output logic vsync_rise,
    output logic vsync_fall
);

    logic hsync_q;
    logic vsync_q;

    // Both syncs idle high, so presetting the history to 1 keeps reset release from faking an edge.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            hsync_q <= i_hsync;
            vsync_q <= i_vsync;
        end
    end

    assign hsync_rise = i_hsync & ~hsync_q;
    assign vsync_rise = i_vsync & ~vsync_q;
    assign vsync_fall = ~i_vsync & vsync_q;

endmodule

// File: rtl/silife_vga_capture.sv
// SiLife VGA capture: samples the centre pixel of every cell in a 640x480@60 stream and emits one
// grid row per strobe. Define SILIFE_CAPTURE_SYNC_CHECK_EN for the line-length check and o_sync_error.
module silife_vga_capture
    import silife_vga_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int HEIGHT     = 32,
    parameter int CELL_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_hsync,
    input  logic                      i_vsync,
    input  logic                      i_data,
    output logic [WIDTH-1:0]          o_cells,
    output logic [$clog2(HEIGHT)-1:0] o_row_select,
    output logic                      o_row_valid,
`ifdef SILIFE_CAPTURE_SYNC_CHECK_EN
    output logic                      o_frame_done,
    output logic                      o_sync_error
`else
    output logic                      o_frame_done
`endif
);

    localparam int RSW  = $clog2(HEIGHT);
    localparam int YW   = $clog2(HEIGHT << CELL_SHIFT) + 1;
    localparam int VBW  = $clog2(V_BACK);
    localparam int HALF = 1 << (CELL_SHIFT - 1);

    localparam logic [H_CNT_W-1:0] SAMPLE_FIRST = H_CNT_W'(H_BACK + HALF);
    localparam logic [H_CNT_W-1:0] LAST_COL     = H_CNT_W'(WIDTH - 1);
    localparam logic [YW-1:0]      LAST_ROW     = YW'(HEIGHT - 1);

    if (CELL_SHIFT < 1 || WIDTH < 2 || HEIGHT < 2 ||
        (WIDTH << CELL_SHIFT) > H_VISIBLE || (HEIGHT << CELL_SHIFT) > V_VISIBLE) begin : g_bad_geometry
        $error("silife_vga_capture: grid of %0dx%0d cells of %0d px does not fit 640x480",
               WIDTH, HEIGHT, 1 << CELL_SHIFT);
    end

    capture_state_t     state;
    capture_state_t     state_next;
    logic               h_rise;
    logic               v_rise;
    logic               v_fall;
    logic               abort;
    logic               sync_err_evt;
    logic [H_CNT_W-1:0] h_cnt;
    logic [H_CNT_W-1:0] h_off;
    logic [H_CNT_W-1:0] col;
    logic [VBW-1:0]     vb_cnt;
    logic [YW-1:0]      y_cnt;
    logic [YW-1:0]      row_idx;
    logic [WIDTH-1:0]   row_buf;
    logic               sample_en;
    logic               row_done;
    logic               frame_last;

    silife_vga_sync_edge u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .i_hsync    (i_hsync),
        .i_vsync    (i_vsync),
        .hsync_rise (h_rise),
        .vsync_rise (v_rise),
        .vsync_fall (v_fall)
    );

`ifdef SILIFE_CAPTURE_SYNC_CHECK_EN
    // h_cnt reads exactly H_TOTAL on the edge that closes a correct-length line.
    assign sync_err_evt = (state == ACTIVE) && h_rise && (h_cnt != H_CNT_W'(H_TOTAL));
`else
    assign sync_err_evt = 1'b0;
`endif

    assign abort = v_fall || sync_err_evt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can leave it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (v_rise) state_next = VBLANK;
            VBLANK: begin
                if (v_fall) begin
                    state_next = IDLE;
                end else if (h_rise && vb_cnt == VBW'(V_BACK - 1)) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE:  if (abort || frame_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // h_cnt is clocks since the last hsync rising edge, so pixel x sits at h_cnt == H_BACK + x.
    always_comb begin
        h_off      = h_cnt - SAMPLE_FIRST;
        col        = h_off >> CELL_SHIFT;
        row_idx    = y_cnt >> CELL_SHIFT;
        sample_en  = (state == ACTIVE) && !abort && !h_rise
                  && (h_cnt >= SAMPLE_FIRST) && (h_off[CELL_SHIFT-1:0] == '0) && (col <= LAST_COL)
                  && (y_cnt[CELL_SHIFT-1:0] == CELL_SHIFT'(HALF)) && (row_idx <= LAST_ROW);
        row_done   = sample_en && (col == LAST_COL);
        frame_last = row_done && (row_idx == LAST_ROW);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt  <= '0;
            vb_cnt <= '0;
            y_cnt  <= '0;
        end else begin
            if (h_rise) begin
                h_cnt <= H_CNT_W'(1);
            end else if (h_cnt != '1) begin
                h_cnt <= h_cnt + 1'b1;
            end

            if (state != VBLANK) begin
                vb_cnt <= '0;
            end else if (h_rise) begin
                vb_cnt <= vb_cnt + 1'b1;
            end

            if (state == VBLANK) begin
                y_cnt <= '0;
            end else if (state == ACTIVE && h_rise && y_cnt != '1) begin
                y_cnt <= y_cnt + 1'b1;
            end
        end
    end

    // NOTE: row_buf is reset like any register; every emitted row is fully overwritten within one line anyway.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_buf <= '0;
        end else if (sample_en) begin
            row_buf <= {i_data, row_buf[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_cells      <= '0;
            o_row_select <= '0;
            o_row_valid  <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_row_valid  <= row_done;
            o_frame_done <= o_row_valid && (o_row_select == RSW'(HEIGHT - 1));
            if (row_done) begin
                o_cells      <= {i_data, row_buf[WIDTH-1:1]};
                o_row_select <= row_idx[RSW-1:0];
            end
        end
    end

`ifdef SILIFE_CAPTURE_SYNC_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_sync_error <= 1'b0;
        end else if (v_rise) begin
            o_sync_error <= 1'b0;
        end else if (sync_err_evt) begin
            o_sync_error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_silife_vga_capture.sv
// Directed bench for silife_vga_capture: drives whole VGA frames from a small generator and
// compares captured rows against hand-written patterns.
module tb_silife_vga_capture;
    import silife_vga_pkg::*;

    localparam int COLS = 32;
    localparam int CS   = 1;
`ifdef SILIFE_CAPTURE_SYNC_CHECK_EN
    localparam int ROWS     = 4;
    localparam int LINE_LEN = H_TOTAL;
    localparam int HS_LOW   = H_SYNC;
`else
    localparam int ROWS     = 32;
    localparam int LINE_LEN = 120;
    localparam int HS_LOW   = 8;
`endif
    localparam int PAT_CHECKER = 0;
    localparam int PAT_CORNERS = 1;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    i_hsync;
    logic                    i_vsync;
    logic                    i_data;
    logic [COLS-1:0]         o_cells;
    logic [$clog2(ROWS)-1:0] o_row_select;
    logic                    o_row_valid;
    logic                    o_frame_done;
`ifdef SILIFE_CAPTURE_SYNC_CHECK_EN
    logic                    o_sync_error;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [COLS-1:0]         cap_cells[$];
    int                      cap_row[$];
    int                      done_cnt = 0;
    int                      cyc = 0;
    int                      last_valid_cyc = 0;
    int                      done_cyc = 0;
    int                      hold_viol = 0;
    logic [COLS-1:0]         prev_cells = '0;
    logic [$clog2(ROWS)-1:0] prev_sel = '0;

    silife_vga_capture #(
        .WIDTH      (COLS),
        .HEIGHT     (ROWS),
        .CELL_SHIFT (CS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .i_data       (i_data),
        .o_cells      (o_cells),
        .o_row_select (o_row_select),
        .o_row_valid  (o_row_valid),
`ifdef SILIFE_CAPTURE_SYNC_CHECK_EN
        .o_frame_done (o_frame_done),
        .o_sync_error (o_sync_error)
`else
        .o_frame_done (o_frame_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: collect strobes, time frame_done, and flag any output change outside a strobe.
    always @(negedge clk) begin
        cyc++;
        if (o_row_valid) begin
            cap_cells.push_back(o_cells);
            cap_row.push_back(int'(o_row_select));
            last_valid_cyc = cyc;
        end
        if (o_frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (reset && !o_row_valid && (o_cells !== prev_cells || o_row_select !== prev_sel)) hold_viol++;
        prev_cells = o_cells;
        prev_sel   = o_row_select;
    end

    function automatic logic [COLS-1:0] row_pattern(input int pat, input int r);
        logic [COLS-1:0] v;
        v = '0;
        if (pat == PAT_CHECKER) begin
            v = (r % 2 == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
        end else if (r == 0) begin
            v = 32'h0000_0001;
        end else if (r == ROWS - 1) begin
            v = 32'h8000_0000;
        end
        return v;
    endfunction

    // One line starts at the hsync rising edge (hc = 0); pixel x is driven at hc = H_BACK + x.
    task automatic drive_line(input logic [COLS-1:0] bits, input bit vis, input int len,
                              input int vs_at, input logic vs_val, input bit noise, input int rst_at);
        int x;
        for (int hc = 0; hc < len; hc++) begin
            @(posedge clk);
            #1;
            i_hsync = (hc < len - HS_LOW);
            if (hc == vs_at) i_vsync = vs_val;
            x = hc - H_BACK;
            if (vis && x >= 0 && x < (COLS << CS)) begin
                i_data = bits[x >> CS];
                if (noise && x == 0) i_data = ~bits[0];
            end else begin
                i_data = noise ? logic'(hc % 2) : 1'b0;
            end
            if (hc == rst_at) begin
                reset = 1'b0;
                #1;
                check("rst_mid_cells", 64'(o_cells), 64'h0);
                check("rst_mid_sel", 64'(o_row_select), 64'h0);
                check("rst_mid_valid", 64'(o_row_valid), 64'h0);
                check("rst_mid_done", 64'(o_frame_done), 64'h0);
            end
            if (hc == rst_at + 3) reset = 1'b1;
        end
    endtask

    // Vsync low across three lines, V_BACK-1 blank lines, then the visible lines and a short porch.
    task automatic drive_frame(input int pat, input int abort_y, input int rst_y, input int short_y,
                               input bit noise);
        drive_line('0, 1'b0, LINE_LEN, LINE_LEN / 2, 1'b0, noise, -1);
        drive_line('0, 1'b0, LINE_LEN, -1, 1'b0, noise, -1);
        drive_line('0, 1'b0, LINE_LEN, LINE_LEN / 2, 1'b1, noise, -1);
        repeat (V_BACK - 1) drive_line('0, 1'b0, LINE_LEN, -1, 1'b0, noise, -1);
        for (int y = 0; y < (ROWS << CS); y++) begin
            drive_line(row_pattern(pat, y >> CS), 1'b1, (y == short_y) ? LINE_LEN - 1 : LINE_LEN,
                       (y == abort_y) ? LINE_LEN / 2 : -1, 1'b0, noise, (y == rst_y) ? 80 : -1);
        end
        repeat (2) drive_line('0, 1'b0, LINE_LEN, -1, 1'b0, noise, -1);
    endtask

    task automatic clear_capture();
        cap_cells.delete();
        cap_row.delete();
        done_cnt = 0;
    endtask

    task automatic check_frame(input string tag, input int pat, input int n_rows, input int n_done);
        check({tag, "_strobes"}, 64'(cap_cells.size()), 64'(n_rows));
        for (int i = 0; i < cap_cells.size() && i < n_rows; i++) begin
            check($sformatf("%s_sel%0d", tag, i), 64'(cap_row[i]), 64'(i));
            check($sformatf("%s_row%0d", tag, i), 64'(cap_cells[i]), 64'(row_pattern(pat, i)));
        end
        check({tag, "_done"}, 64'(done_cnt), 64'(n_done));
        if (done_cnt == 1 && n_done == 1) check({tag, "_done_lat"}, 64'(done_cyc - last_valid_cyc), 64'h1);
    endtask

    initial begin
        #1_500_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        i_hsync = 1'b1;
        i_vsync = 1'b1;
        i_data  = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_cells", 64'(o_cells), 64'h0);
        check("rst_sel", 64'(o_row_select), 64'h0);
        check("rst_valid", 64'(o_row_valid), 64'h0);
        check("rst_done", 64'(o_frame_done), 64'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);

`ifdef SILIFE_CAPTURE_SYNC_CHECK_EN
        check("sync_err_reset", 64'(o_sync_error), 64'h0);
        clear_capture();
        drive_frame(PAT_CHECKER, -1, -1, 3, 1'b0);
        check("sync_err_set", 64'(o_sync_error), 64'h1);
        check_frame("sync_abort", PAT_CHECKER, 2, 0);
        clear_capture();
        drive_frame(PAT_CHECKER, -1, -1, -1, 1'b0);
        check("sync_err_clear", 64'(o_sync_error), 64'h0);
        check_frame("sync_next", PAT_CHECKER, ROWS, 1);
`else
        clear_capture();
        drive_frame(PAT_CHECKER, -1, -1, -1, 1'b0);
        check_frame("checker", PAT_CHECKER, ROWS, 1);

        clear_capture();
        drive_frame(PAT_CORNERS, -1, -1, -1, 1'b0);
        check_frame("corners", PAT_CORNERS, ROWS, 1);

        clear_capture();
        drive_frame(PAT_CHECKER, 20, -1, -1, 1'b0);
        check_frame("abort", PAT_CHECKER, 10, 0);

        // Frame after the abort also carries noise in blanking and an inverted pixel at x = 0.
        clear_capture();
        drive_frame(PAT_CHECKER, -1, -1, -1, 1'b1);
        check_frame("glitch", PAT_CHECKER, ROWS, 1);

        clear_capture();
        drive_frame(PAT_CORNERS, -1, 11, -1, 1'b0);
        check_frame("rst_frame", PAT_CORNERS, 5, 0);
        check("rst_frame_cells", 64'(o_cells), 64'h0);
`endif
        check("hold_stable", 64'(hold_viol), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/silife_vga_capture.md
SILIFE_VGA_CAPTURE -- requirements
Module: silife_vga_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 32: cells per row.
REQ-002 SHALL have parameter HEIGHT, default 32: rows per frame.
REQ-003 SHALL have parameter CELL_SHIFT, default 3: cell edge is 2^CELL_SHIFT pixels.
REQ-004 SHALL have port clk  input  1: pixel clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port i_hsync  input  1: VGA hsync, active-low.
REQ-007 SHALL have port i_vsync  input  1: VGA vsync, active-low.
REQ-008 SHALL have port i_data  input  1: pixel value, 1 = live cell.
REQ-009 SHALL have port o_cells  output  WIDTH: captured row; bit c = column c.
REQ-010 SHALL have port o_row_select  output  $clog2(HEIGHT): index of the row in o_cells.
REQ-011 SHALL have port o_row_valid  output  1: one-cycle strobe; o_cells/o_row_select valid on it.
REQ-012 SHALL have port o_frame_done  output  1: one-cycle strobe after row HEIGHT-1 is emitted.

Function
REQ-013 SHALL use states IDLE, VBLANK, ACTIVE: IDLE->VBLANK on vsync rising edge (end of pulse); VBLANK->ACTIVE on the V_BACK-th hsync rising edge counted in VBLANK; ACTIVE->IDLE after row HEIGHT-1 is emitted.
REQ-014 SHALL define pixel x=0 as the cycle H_BACK clocks after an hsync rising edge; x increments once per clock.
REQ-015 SHALL define line y=0 as the line starting at the hsync rising edge that causes VBLANK->ACTIVE; y increments on each later hsync rising edge.
REQ-016 SHALL sample i_data only at x = (c<<CELL_SHIFT) + 2^(CELL_SHIFT-1), c in 0..WIDTH-1, on lines with y mod 2^CELL_SHIFT = 2^(CELL_SHIFT-1).
REQ-017 SHALL shift sampled bits into a WIDTH-bit row buffer; bit c equals sample c.
REQ-018 SHALL load o_cells, set o_row_select = y>>CELL_SHIFT and pulse o_row_valid the cycle after sample c = WIDTH-1.
REQ-019 SHALL hold o_cells and o_row_select stable between o_row_valid strobes.
REQ-020 SHALL pulse o_frame_done the cycle after the o_row_valid of row HEIGHT-1.
REQ-021 SHALL, on a vsync falling edge in VBLANK or ACTIVE, abandon the frame: no further strobes, no o_frame_done, go to IDLE.
REQ-022 SHALL ignore i_data in IDLE, VBLANK, and outside sample points.
REQ-023 SHALL NOT emit a row whose hsync arrives before sample WIDTH-1; partial row is discarded.

Reset
REQ-024 SHALL, while reset is low, force state IDLE, o_cells=0, o_row_select=0, o_row_valid=0, o_frame_done=0, all counters 0.
REQ-025 SHALL resume capture only after the first vsync rising edge following reset release.

Configuration
REQ-026 SHALL implement the line-length check only when SILIFE_CAPTURE_SYNC_CHECK_EN is defined. It adds output o_sync_error (1 bit, reset 0). It is set when two consecutive hsync rising edges in ACTIVE are not H_TOTAL clocks apart, and the frame is then aborted per REQ-021. It is cleared at the next vsync rising edge.
REQ-027 SHALL, without SILIFE_CAPTURE_SYNC_CHECK_EN, have no o_sync_error port and no line-length counter.

Structure
REQ-028 SHALL take H_BACK=48, V_BACK=33 and H_TOTAL=800 (640x480@60) from shared package silife_vga_pkg, alongside the generator's timing constants.
REQ-029 SHALL place sync edge detection (registered i_hsync/i_vsync, rising/falling strobes) in sub-module silife_vga_sync_edge.
REQ-030 SHALL require WIDTH<<CELL_SHIFT <= 640 and HEIGHT<<CELL_SHIFT <= 480 (elaboration check).

Verification
REQ-031 SHALL cover: feeding the generator's output for a checkerboard grid -> 32 o_row_valid strobes, row r = 32'h55555555 or 32'hAAAAAAAA alternating, then one o_frame_done.
REQ-032 SHALL cover: only cell (0,0) and cell (31,31) live -> row 0 = 32'h00000001, row 31 = 32'h80000000, all others 0.
REQ-033 SHALL cover: vsync pulse injected at row 10 -> no strobes for rows 10..31, no o_frame_done, and the next full frame is captured correctly.
REQ-034 SHALL cover: reset asserted mid-row 5 -> all outputs 0 within the cycle; after release, no strobe until a vsync rising edge.
REQ-035 SHALL cover: with SILIFE_CAPTURE_SYNC_CHECK_EN defined, one line of 799 clocks -> o_sync_error=1, frame aborted, and o_sync_error=0 after the next vsync rising edge.
REQ-036 SHALL cover: single-pixel glitch on i_data at x=0 of a sample line -> captured row unaffected.
